// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the i2c_cmd_sequencer.
// State encoding, axi_i2c register offsets and the AXI OKAY response code.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_RESP  = 3'd2,
        GAP      = 3'd3,
        RD_REQ   = 3'd4,
        RD_RESP  = 3'd5,
        RESP     = 3'd6
    } state_e;

    localparam logic [11:0] OFF_CTRL = 12'h0;
    localparam logic [11:0] OFF_ADDR = 12'h4;
    localparam logic [11:0] OFF_TX   = 12'h8;
    localparam logic [11:0] OFF_RX   = 12'hC;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: AXI4-Lite master that runs one full axi_i2c transfer
// (write CTRL, write ADDR, write TX, idle gap, read RX) per accepted command.
// Optional feature macro: I2C_SEQ_TIMEOUT_EN adds a per-handshake watchdog
// that aborts a stalled transfer after TIMEOUT_CYC clocks with rsp_err=1.
//
// Handshake semantics (command, response and every AXI channel): a beat
// transfers on a rising edge where valid and ready are both high; a valid,
// once raised, stays high with stable payload until that edge, and no valid
// output here is ever derived combinationally from a ready input.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR   = 12'h000,
    parameter logic [31:0] CTRL_VALUE  = 32'h0000_0001,
    parameter int          GAP_CYCLES  = 8,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output state_e      fsm_state,
    output logic [11:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [11:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    // GAP counter loads GAP_CYCLES-1 and counts down to zero; never used when GAP_CYCLES is 0.
    localparam int                GAP_W    = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e            state;
    logic [1:0]        idx;
    logic [6:0]        lat_addr;
    logic [7:0]        lat_data;
    logic              err;
    logic              aw_done;
    logic              w_done;
    logic [GAP_W-1:0]  gap_cnt;
    logic              aw_fin;
    logic              w_fin;
    logic              unused_rdata;

    assign fsm_state    = state;
    assign m_axi_wstrb  = 4'hF;
    assign unused_rdata = ^m_axi_rdata[31:8];

    // A write phase completes once both AW and W have handshaken, in either order.
    assign aw_fin = aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_fin  = w_done  | (m_axi_wvalid  & m_axi_wready);

    // Register address for write index 0/1/2.
    function automatic logic [11:0] reg_addr(input logic [1:0] i);
        logic [11:0] off;
        case (i)
            2'd0:    off = OFF_CTRL;
            2'd1:    off = OFF_ADDR;
            default: off = OFF_TX;
        endcase
        return BASE_ADDR + off;
    endfunction

    // Write data for index 0/1/2, from the latched command fields.
    function automatic logic [31:0] reg_data(input logic [1:0] i, input logic [6:0] a,
                                             input logic [7:0] d);
        case (i)
            2'd0:    return CTRL_VALUE;
            2'd1:    return {25'b0, a};
            default: return {24'b0, d};
        endcase
    endfunction

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_watch;
    logic            wd_leave;
    logic            wd_hit;

    // Watchdog bookkeeping: which states are watched and whether this cycle leaves the state.
    always_comb begin
        wd_watch = 1'b0;
        wd_leave = 1'b0;
        case (state)
            WR_REQ:  begin wd_watch = 1'b1; wd_leave = aw_fin & w_fin;  end
            WR_RESP: begin wd_watch = 1'b1; wd_leave = m_axi_bvalid;    end
            RD_REQ:  begin wd_watch = 1'b1; wd_leave = m_axi_arready;   end
            RD_RESP: begin wd_watch = 1'b1; wd_leave = m_axi_rvalid;    end
            default: begin wd_watch = 1'b0; wd_leave = 1'b0;            end
        endcase
        wd_hit = wd_watch && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    end

    // Watchdog counts clocks spent in one watched state and clears on any state change.
    always_ff @(posedge clk) begin
        if (reset || !wd_watch || wd_leave || wd_hit) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    // Main sequencer FSM; every port output is a register set on the transition edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= 2'd0;
            lat_addr      <= '0;
            lat_data      <= '0;
            err           <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            gap_cnt       <= '0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
`ifdef I2C_SEQ_TIMEOUT_EN
            if (wd_hit) begin
                // Stalled handshake: abandon the beat and report an error.
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
                err           <= 1'b1;
                rsp_err       <= 1'b1;
                rsp_data      <= '0;
                rsp_valid     <= 1'b1;
                state         <= RESP;
            end else
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        lat_addr      <= cmd_addr;
                        lat_data      <= cmd_data;
                        err           <= 1'b0;
                        idx           <= 2'd0;
                        cmd_ready     <= 1'b0;
                        busy          <= 1'b1;
                        m_axi_awaddr  <= reg_addr(2'd0);
                        m_axi_wdata   <= reg_data(2'd0, cmd_addr, cmd_data);
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != AXI_RESP_OKAY) begin
                            err       <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (idx < 2'd2) begin
                            idx           <= idx + 2'd1;
                            m_axi_awaddr  <= reg_addr(idx + 2'd1);
                            m_axi_wdata   <= reg_data(idx + 2'd1, lat_addr, lat_data);
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else if (GAP_CYCLES == 0) begin
                            m_axi_araddr  <= BASE_ADDR + OFF_RX;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        m_axi_araddr  <= BASE_ADDR + OFF_RX;
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_REQ;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_data     <= m_axi_rdata[7:0];
                        rsp_err      <= err | (m_axi_rresp != AXI_RESP_OKAY);
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed testbench for i2c_cmd_sequencer with a small axi_i2c slave model
// (RX reads back last TX byte + 1). Watchdog case runs when
// I2C_SEQ_TIMEOUT_EN is defined.
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    localparam int GAP = 8;
    localparam int TO  = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_data, rsp_data;
    state_e      fsm_state;
    logic [11:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    i2c_cmd_sequencer #(
        .BASE_ADDR(12'h000), .CTRL_VALUE(32'h1), .GAP_CYCLES(GAP), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .fsm_state(fsm_state),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // ---------------- slave model ----------------
    int          aw_lat = 0, w_lat = 0, b_lat = 0, err_idx = -1;
    logic        ar_block = 1'b0;
    int          aw_cnt, w_cnt, b_cnt;
    logic        got_aw, got_w;
    logic [11:0] last_awaddr, last_araddr;
    logic [31:0] last_wdata;
    logic [7:0]  last_tx;
    int          wr_issued = 0, aw_beats = 0, w_beats = 0, rd_beats = 0;
    logic [43:0] wr_log[$];

    assign awready = awvalid && (aw_cnt >= aw_lat);
    assign wready  = wvalid  && (w_cnt  >= w_lat);
    assign arready = arvalid && !ar_block;

    always @(posedge clk) begin
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            last_tx <= '0;
        end else begin
            if (awvalid && awready) begin
                last_awaddr <= awaddr; got_aw <= 1'b1; aw_cnt <= 0; aw_beats <= aw_beats + 1;
            end else if (awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                last_wdata <= wdata; got_w <= 1'b1; w_cnt <= 0; w_beats <= w_beats + 1;
            end else if (wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if (bvalid) begin
                if (bready) bvalid <= 1'b0;
            end else if (got_aw && got_w) begin
                if (b_cnt >= b_lat) begin
                    bvalid <= 1'b1;
                    bresp  <= (wr_issued == err_idx) ? 2'b10 : 2'b00;
                    wr_log.push_back({last_awaddr, last_wdata});
                    if (last_awaddr == 12'h008) last_tx <= last_wdata[7:0];
                    wr_issued <= wr_issued + 1;
                    got_aw <= 1'b0; got_w <= 1'b0; b_cnt <= 0;
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1; rresp <= 2'b00;
                rdata <= {24'b0, last_tx + 8'd1};
                last_araddr <= araddr; rd_beats <= rd_beats + 1;
            end
        end
    end

    // Bus timing monitor: B handshake cycle, arvalid rise cycle, arvalid-high cycles.
    int   cyc = 0, last_b_cyc = 0, ar_rise_cyc = 0, ar_high = 0;
    logic arvalid_q = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bvalid && bready) last_b_cyc <= cyc;
        if (arvalid && !arvalid_q) ar_rise_cyc <= cyc;
        if (arvalid) ar_high <= ar_high + 1;
        arvalid_q <= arvalid;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0, n_bad = 0;
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
        check_eq("cmd_ready_wait", cmd_ready, 1);
        cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [7:0] exp_d, input logic exp_e);
        int n = 0;
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
        check_eq({tag, "_rsp"}, {rsp_err, rsp_data}, {exp_e, exp_d});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_idle"}, {cmd_ready, busy}, 2'b10);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base, rb, ab, wb, ah;
        cmd_valid = 0; cmd_addr = 0; cmd_data = 0; rsp_ready = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // reset state: {awv,wv,bready,arv,rready,rsp_valid,busy,cmd_ready}
        check_eq("reset_ctl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready},
                 8'b0000_0001);
        check_eq("reset_rsp", {rsp_err, rsp_data}, 9'h000);
        check_eq("reset_state", fsm_state, IDLE);

        // 1. basic transfer
        base = wr_log.size(); rb = rd_beats;
        exp_q.push_back(8'hA6);
        send_cmd(7'h50, 8'hA5);
        get_rsp("basic", exp_q.pop_front(), 1'b0);
        check_eq("basic_nwr", wr_log.size() - base, 3);
        check_eq("basic_wr0", wr_log[base],     {12'h000, 32'h1});
        check_eq("basic_wr1", wr_log[base + 1], {12'h004, 32'h50});
        check_eq("basic_wr2", wr_log[base + 2], {12'h008, 32'hA5});
        check_eq("basic_nrd", rd_beats - rb, 1);
        check_eq("basic_araddr", last_araddr, 12'h00C);
        check_eq("basic_gap", ar_rise_cyc - last_b_cyc, GAP + 1);
        check_eq("basic_wstrb", wstrb, 4'hF);

        // 2. AW/W skew: wready 3 clks ahead of awready
        aw_lat = 3; w_lat = 0;
        base = wr_log.size(); ab = aw_beats; wb = w_beats;
        send_cmd(7'h50, 8'hA5);
        get_rsp("skew", 8'hA6, 1'b0);
        check_eq("skew_nw", w_beats - wb, 3);
        check_eq("skew_naw", aw_beats - ab, 3);
        check_eq("skew_wr2", wr_log[base + 2], {12'h008, 32'hA5});
        aw_lat = 0;

        // 3. error on ADDR write
        err_idx = wr_issued + 1;
        base = wr_log.size(); rb = rd_beats;
        send_cmd(7'h50, 8'hA5);
        get_rsp("err", 8'h00, 1'b1);
        check_eq("err_nwr", wr_log.size() - base, 2);
        check_eq("err_nrd", rd_beats - rb, 0);
        err_idx = -1;

        // 4. response backpressure with an ignored second command
        base = wr_log.size();
        send_cmd(7'h12, 8'h34);
        for (int n = 0; n < 500 && !rsp_valid; n++) @(negedge clk);
        cmd_addr = 7'h7F; cmd_data = 8'hFF; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp_hold", {rsp_valid, rsp_err, rsp_data, cmd_ready, busy},
                     {1'b1, 1'b0, 8'h35, 1'b0, 1'b1});
        end
        cmd_valid = 1'b0;
        check_eq("bp_nwr", wr_log.size() - base, 3);
        get_rsp("bp", 8'h35, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("bp_not_queued", {wr_log.size() - base, 1'b0 + busy}, {32'd3, 1'b0});

        // 5. reset during WR_RESP of the TX write
        b_lat = 4; wb = w_beats;
        send_cmd(7'h33, 8'h44);
        for (int n = 0; n < 200 && (w_beats - wb) < 3; n++) @(negedge clk);
        check_eq("rst_mid_state", fsm_state, WR_RESP);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_ctl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready},
                 8'b0000_0001);
        reset = 1'b0; b_lat = 0;
        send_cmd(7'h22, 8'h10);
        get_rsp("post_rst", 8'h11, 1'b0);

`ifdef I2C_SEQ_TIMEOUT_EN
        // 6. read address never accepted
        ar_block = 1'b1; ah = ar_high;
        send_cmd(7'h50, 8'hA5);
        get_rsp("wdog", 8'h00, 1'b1);
        check_eq("wdog_ar_cycles", ar_high - ah, TO);
        check_eq("wdog_arvalid", arvalid, 0);
        ar_block = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
